// File: rtl/hfusion_sched_pkg.sv
// Shared types and helpers for the hfusion multi-pass scheduler.
package hfusion_sched_pkg;

  typedef enum logic [1:0] {IDLE, PASS, DRAIN, FIN} state_t;

  function automatic int calc_n(input int im_len, input int im_wid);
    return im_len * im_wid;
  endfunction

  localparam int DEF_IM_LEN = 520;
  localparam int DEF_IM_WID = 520;
  localparam int DEF_N      = calc_n(DEF_IM_LEN, DEF_IM_WID);

  // Pass p writes bank p[0]; the fused bank read by pass p is the other one.
  function automatic logic bank_of(input logic [15:0] p);
    return p[0];
  endfunction

endpackage

// File: rtl/hsched_vdelay.sv
// Valid delay line: replays the read-valid stream PIPE_LAT cycles later as write enable.
module hsched_vdelay #(
  parameter int DEPTH = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_reg <= '0;
    else      sr_reg <= {sr_reg[DEPTH-2:0], din};
  end

  assign dout = sr_reg[DEPTH-1];

endmodule

// File: rtl/hfusion_sched.sv
// Multi-pass fusion scheduler: raster reads per pass, pipeline drain, ping-pong
// fused banks and aligned write-back addressing.
module hfusion_sched
  import hfusion_sched_pkg::*;
#(
  parameter int IM_LEN            = DEF_IM_LEN,
  parameter int IM_WID            = DEF_IM_WID,
  parameter int LOG2_NO_OF_IMAGES = 4,
  parameter int PIPE_LAT          = 20,
  parameter int ADDR_W            = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LOG2_NO_OF_IMAGES:0]   num_images,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_valid,
  output logic [LOG2_NO_OF_IMAGES-1:0] rd_new_img,
  output logic                         rd_fuse_from_img0,
  output logic                         rd_fuse_bank,
  output logic                         clearbuffer,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         wr_en,
  output logic                         wr_bank,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         result_bank
);

  localparam int N  = calc_n(IM_LEN, IM_WID);
  localparam int PW = LOG2_NO_OF_IMAGES + 1;
  localparam int DW = $clog2(PIPE_LAT);
  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(N - 1);
  localparam logic [DW-1:0]     LAST_DRAIN = DW'(PIPE_LAT - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pix_reg, pix_next;
  logic [DW-1:0]     drain_reg, drain_next;
  logic [PW-1:0]     p_reg, p_next;
  logic [PW-1:0]     k_reg, k_next;

  logic                         rd_valid_next, from_img0_next, fuse_bank_next;
  logic                         clearbuffer_next, wr_bank_next, busy_next;
  logic                         done_next, err_next, result_bank_next;
  logic [LOG2_NO_OF_IMAGES-1:0] rd_new_img_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      pix_reg   <= '0;
      drain_reg <= '0;
      p_reg     <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      pix_reg   <= pix_next;
      drain_reg <= drain_next;
      p_reg     <= p_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pix_next   = pix_reg;
    drain_next = drain_reg;
    p_next     = p_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (start && num_images >= PW'(2)) begin
          k_next     = num_images;
          p_next     = PW'(1);
          pix_next   = '0;
          state_next = PASS;
        end
      end
      PASS: begin
        if (pix_reg == LAST_PIX) begin
          pix_next   = '0;
          drain_next = '0;
          state_next = DRAIN;
        end else begin
          pix_next = pix_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_reg == LAST_DRAIN) begin
          drain_next = '0;
          if (p_reg < k_reg - PW'(1)) begin
            p_next     = p_reg + PW'(1);
            state_next = PASS;
          end else begin
            state_next = FIN;
          end
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    rd_valid_next    = (state_next == PASS);
    rd_new_img_next  = p_next[LOG2_NO_OF_IMAGES-1:0];
    from_img0_next   = (state_next == PASS) && (p_next == PW'(1));
    fuse_bank_next   = 1'b0;
    if ((state_next == PASS) && (p_next != PW'(1)))
      fuse_bank_next = ~bank_of(16'(p_next));
    clearbuffer_next = (state_next == PASS) && (pix_next == LAST_PIX);
    wr_bank_next     = (state_next == PASS) ? bank_of(16'(p_next)) : wr_bank;
    busy_next        = (state_next != IDLE);
    done_next        = (state_next == FIN);
    err_next         = (state_reg == IDLE) && start && (num_images < PW'(2));
    result_bank_next = (state_next == FIN) ? bank_of(16'(k_reg - PW'(1))) : result_bank;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr           <= '0;
      rd_valid          <= 1'b0;
      rd_new_img        <= '0;
      rd_fuse_from_img0 <= 1'b0;
      rd_fuse_bank      <= 1'b0;
      clearbuffer       <= 1'b0;
      wr_bank           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      result_bank       <= 1'b0;
    end else begin
      rd_addr           <= pix_next;
      rd_valid          <= rd_valid_next;
      rd_new_img        <= rd_new_img_next;
      rd_fuse_from_img0 <= from_img0_next;
      rd_fuse_bank      <= fuse_bank_next;
      clearbuffer       <= clearbuffer_next;
      wr_bank           <= wr_bank_next;
      busy              <= busy_next;
      done              <= done_next;
      err               <= err_next;
      result_bank       <= result_bank_next;
    end
  end

  hsched_vdelay #(.DEPTH(PIPE_LAT)) u_vdelay (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_valid),
    .dout (wr_en)
  );

  // wr_addr shows the address being written while wr_en is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wr_addr <= '0;
    else if (wr_en)
      wr_addr <= (wr_addr == LAST_PIX) ? '0 : wr_addr + ADDR_W'(1);
  end

endmodule

// File: tb/tb_hfusion_sched.sv
// Self-checking bench for hfusion_sched: cycle-accurate model derived from elapsed run time.
module tb_hfusion_sched;

  localparam int IM_LEN = 4;
  localparam int IM_WID = 3;
  localparam int LOG2   = 4;
  localparam int PL     = 5;
  localparam int AW     = 8;
  localparam int N      = IM_LEN * IM_WID;
  localparam int P      = N + PL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LOG2:0] num_images = '0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_valid, rd_fuse_from_img0, rd_fuse_bank, clearbuffer;
  logic          wr_en, wr_bank, busy, done, err, result_bank;
  logic [LOG2-1:0] rd_new_img;

  hfusion_sched #(
    .IM_LEN(IM_LEN), .IM_WID(IM_WID), .LOG2_NO_OF_IMAGES(LOG2),
    .PIPE_LAT(PL), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_images(num_images),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_new_img(rd_new_img),
    .rd_fuse_from_img0(rd_fuse_from_img0), .rd_fuse_bank(rd_fuse_bank),
    .clearbuffer(clearbuffer), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_bank(wr_bank), .busy(busy), .done(done), .err(err),
    .result_bank(result_bank)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: a run is described only by its start cycle and K.
  bit m_busy = 0, m_fin_pending = 0, m_have = 0, m_res = 0;
  int m_t0 = 0, m_k = 0;

  typedef struct {
    int k;
    int exp_cycles;
    bit exp_bank;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs(input bit exp_err);
    int r, fin_r, pass, off, rw;
    bit exp_we;
    chk("err", 32'(err), 32'(exp_err));
    if (!m_busy) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rd_valid", 32'(rd_valid), 0);
      chk("idle_wr_en", 32'(wr_en), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_clearbuffer", 32'(clearbuffer), 0);
      if (m_have) chk("result_bank_hold", 32'(result_bank), 32'(m_res));
      return;
    end
    r     = cyc - m_t0;
    fin_r = (m_k - 1) * P;
    chk("busy", 32'(busy), 1);
    if (r == fin_r) begin
      chk("done", 32'(done), 1);
      chk("fin_rd_valid", 32'(rd_valid), 0);
      chk("fin_wr_en", 32'(wr_en), 0);
      m_res = ((m_k - 1) % 2) != 0;
      m_have = 1;
      chk("result_bank", 32'(result_bank), 32'(m_res));
      m_fin_pending = 1;
      $display("run done K=%0d cycle=%0d result_bank=%0d", m_k, cyc, result_bank);
      return;
    end
    chk("done_low", 32'(done), 0);
    pass = r / P + 1;
    off  = r % P;
    chk("rd_valid", 32'(rd_valid), 32'(off < N));
    if (off < N) begin
      chk("rd_addr", 32'(rd_addr), 32'(off));
      chk("clearbuffer", 32'(clearbuffer), 32'(off == N - 1));
      chk("rd_new_img", 32'(rd_new_img), 32'(pass));
      chk("fuse_from_img0", 32'(rd_fuse_from_img0), 32'(pass == 1));
      if (pass > 1) chk("rd_fuse_bank", 32'(rd_fuse_bank), 32'(pass % 2 == 0));
    end else begin
      chk("drain_clearbuffer", 32'(clearbuffer), 0);
    end
    rw = r - PL;
    exp_we = (rw >= 0) && ((rw % P) < N);
    chk("wr_en", 32'(wr_en), 32'(exp_we));
    if (exp_we) begin
      chk("wr_addr", 32'(wr_addr), 32'(rw % P));
      chk("wr_bank", 32'(wr_bank), 32'((rw / P + 1) % 2));
    end
  endtask

  task automatic tick(input bit st, input int ni);
    bit exp_err;
    start = st;
    num_images = ni[LOG2:0];
    @(posedge clk);
    cyc++;
    exp_err = !m_busy && st && (ni < 2);
    if (m_fin_pending) begin
      m_busy = 0;
      m_fin_pending = 0;
    end else if (!m_busy && st && ni >= 2) begin
      m_busy = 1;
      m_t0 = cyc;
      m_k = ni;
      $display("run start K=%0d cycle=%0d", ni, cyc);
    end
    #1 start = 1'b0;
    @(negedge clk);
    check_outputs(exp_err);
  endtask

  task automatic run_count(input int k, input int repulse_r, output int cnt);
    int guard;
    cnt = 0;
    guard = 0;
    tick(1, k);
    while (guard < 400) begin
      if (busy) cnt++;
      if (done) break;
      tick((repulse_r >= 0) && (cyc - m_t0 == repulse_r), 2);
      guard++;
    end
    if (guard >= 400) chk("run_timeout", 0, 1);
    tick(0, 0);
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    #1;
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_new_img", 32'(rd_new_img), 0);
    chk("rst_from_img0", 32'(rd_fuse_from_img0), 0);
    chk("rst_fuse_bank", 32'(rd_fuse_bank), 0);
    chk("rst_clearbuffer", 32'(clearbuffer), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_bank", 32'(wr_bank), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_result_bank", 32'(result_bank), 0);
    m_busy = 0; m_fin_pending = 0; m_have = 1; m_res = 0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt, guard;
    tbl[0] = '{k: 2, exp_cycles: 18, exp_bank: 1'b1};
    tbl[1] = '{k: 4, exp_cycles: 52, exp_bank: 1'b1};
    tbl[2] = '{k: 3, exp_cycles: 35, exp_bank: 1'b0};
    tbl[3] = '{k: 5, exp_cycles: 69, exp_bank: 1'b0};

    @(negedge clk);
    hold_reset();

    for (int i = 0; i < 4; i++) begin
      run_count(tbl[i].k, -1, cnt);
      chk("run_cycles", 32'(cnt), 32'(tbl[i].exp_cycles));
      chk("table_result_bank", 32'(result_bank), 32'(tbl[i].exp_bank));
    end

    // Rejected starts
    tick(1, 1);
    chk("reject1_busy", 32'(busy), 0);
    tick(1, 0);
    chk("reject0_rd_valid", 32'(rd_valid), 0);
    tick(0, 0);
    chk("reject_busy_after", 32'(busy), 0);

    // Start re-pulsed during pass 2 is ignored
    run_count(4, P + 3, cnt);
    chk("repulse_cycles", 32'(cnt), 52);

    // Reset at pass 2, pixel 6
    tick(1, 3);
    repeat (P + 6) tick(0, 0);
    chk("pre_rst_addr", 32'(rd_addr), 6);
    chk("pre_rst_img", 32'(rd_new_img), 2);
    hold_reset();
    run_count(2, -1, cnt);
    chk("post_rst_cycles", 32'(cnt), 18);

    // Back-to-back: start in the cycle after done
    run_count(2, -1, cnt);
    tick(1, 3);
    chk("b2b_rd_valid", 32'(rd_valid), 1);
    chk("b2b_rd_addr", 32'(rd_addr), 0);
    chk("b2b_wr_en", 32'(wr_en), 0);
    guard = 0;
    while (m_busy && guard < 300) begin
      tick(0, 0);
      guard++;
    end
    if (guard >= 300) chk("b2b_timeout", 0, 1);

    // Randomized runs with stray starts
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) tick($urandom_range(0, 3) == 0, $urandom_range(0, 1));
      tick(1, $urandom_range(0, 5));
      guard = 0;
      while (m_busy && guard < 300) begin
        tick($urandom_range(0, 7) == 0, $urandom_range(0, 5));
        guard++;
      end
      if (guard >= 300) chk("rand_timeout", 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
